// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for the LEGv8 multicycle datapath.
//
// Sequences FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK from the latched
// opcode and drives every datapath enable and mux select as a Moore
// function of state. The only exception is BRANCH, where PCWrite follows
// Zero combinationally.
//
// Optional feature: define CBNZ_EN to decode 10110101xxx as CBNZ.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset (state -> FETCH)
//   Op[10:0]  in   instruction bits [31:21] from the instruction register
//   Zero      in   ALU zero flag, used only in BRANCH
//   PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, Reg2Loc,
//   RegWrite, MemtoReg, ALUSrcA   out  1-bit datapath controls
//   ALUSrcB[1:0], ALUOp[1:0]      out  ALU operand / operation selects
//   state[3:0]                    out  current state encoding (debug)
//   illegal                       out  sticky illegal-opcode flag
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [3:0]  state,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_ILLEGAL  = 4'd9
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;

  logic w_ldur, w_stur, w_rtype, w_cbz, w_cbnz, w_reg2loc_op;

  assign w_ldur  = (Op == 11'b11111000010);
  assign w_stur  = (Op == 11'b11111000000);
  assign w_rtype = (Op == 11'b10001011000) || (Op == 11'b11001011000) ||
                   (Op == 11'b10001010000) || (Op == 11'b10101010000);
  assign w_cbz   = (Op[10:3] == 8'b10110100);
`ifdef CBNZ_EN
  assign w_cbnz  = (Op[10:3] == 8'b10110101);
`else
  assign w_cbnz  = 1'b0;
`endif
  assign w_reg2loc_op = w_stur | w_cbz | w_cbnz;

  // State register; the illegal flag is set on the edge that enters ILLEGAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == S_ILLEGAL);
    end
  end

  // Next-state logic; unused encodings fall to ILLEGAL.
  always_comb begin
    w_next = S_ILLEGAL;
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        if (w_ldur || w_stur)       w_next = S_MEMADDR;
        else if (w_rtype)           w_next = S_EXEC_R;
        else if (w_cbz || w_cbnz)   w_next = S_BRANCH;
        else                        w_next = S_ILLEGAL;
      end
      S_MEMADDR: begin
        if (w_ldur)      w_next = S_MEMREAD;
        else if (w_stur) w_next = S_MEMWRITE;
        else             w_next = S_ILLEGAL;
      end
      S_MEMREAD:  w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = S_FETCH;
      S_EXEC_R:   w_next = S_RWB;
      S_RWB:      w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_ILLEGAL;
    endcase
  end

  // Moore outputs; everything is held at 0 while reset is high, so FETCH's
  // strobes do not leak out during reset.
  always_comb begin
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = '0;
    ALUOp    = '0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          Reg2Loc = w_reg2loc_op;
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          Reg2Loc = w_reg2loc_op;
        end
        S_MEMREAD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          Reg2Loc  = w_reg2loc_op;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 1'b1;
          PCWrite = w_cbnz ? ~Zero : Zero;
          Reg2Loc = w_reg2loc_op;
        end
        default: ;
      endcase
    end
  end

  assign state   = r_state;
  assign illegal = r_illegal & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- randomized self-checking bench for multicycle_ctrl.
// The reference model maps each opcode to an instruction class, the class
// to its expected state walk, and each (state, class, Zero) to the expected
// control word.
module tb_multicycle_ctrl;

  logic        clk;
  logic        reset;
  logic [10:0] Op;
  logic        Zero;
  logic        PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite;
  logic        Reg2Loc, RegWrite, MemtoReg, ALUSrcA, illegal;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam int K_LDUR = 0, K_STUR = 1, K_RTYPE = 2, K_CBZ = 3,
                 K_CBNZ = 4, K_ILL = 5;

  multicycle_ctrl u_dut (
    .clk      (clk),
    .reset    (reset),
    .Op       (Op),
    .Zero     (Zero),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .Reg2Loc  (Reg2Loc),
    .RegWrite (RegWrite),
    .MemtoReg (MemtoReg),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .state    (state),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order:
  // PCWrite PCSrc IorD MemRead MemWrite IRWrite Reg2Loc RegWrite MemtoReg
  // ALUSrcA ALUSrcB[1:0] ALUOp[1:0] illegal
  logic [14:0] w_outs;
  assign w_outs = {PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, Reg2Loc,
                   RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, illegal};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic int op_kind(input logic [10:0] op);
    if (op == 11'b11111000010) return K_LDUR;
    if (op == 11'b11111000000) return K_STUR;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_RTYPE;
    if (op[10:3] == 8'b10110100) return K_CBZ;
`ifdef CBNZ_EN
    if (op[10:3] == 8'b10110101) return K_CBNZ;
`endif
    return K_ILL;
  endfunction

  function automatic int walk_len(input int k);
    case (k)
      K_LDUR:        return 5;
      K_STUR, K_RTYPE: return 4;
      default:       return 3;
    endcase
  endfunction

  // Expected state at cycle idx of an instruction of class k.
  function automatic int walk_state(input int k, input int idx);
    int unsigned ld [5] = '{0, 1, 2, 3, 4};
    int unsigned st [4] = '{0, 1, 2, 5};
    int unsigned rt [4] = '{0, 1, 6, 7};
    int unsigned br [3] = '{0, 1, 8};
    int unsigned il [3] = '{0, 1, 9};
    case (k)
      K_LDUR:  return int'(ld[idx]);
      K_STUR:  return int'(st[idx]);
      K_RTYPE: return int'(rt[idx]);
      K_ILL:   return int'(il[idx]);
      default: return int'(br[idx]);
    endcase
  endfunction

  function automatic logic [14:0] exp_outs(input int st, input int k,
                                           input logic z);
    logic pcw = 0, pcs = 0, iord = 0, mr = 0, mw = 0, irw = 0, r2l = 0;
    logic rw = 0, m2r = 0, sa = 0, ill = 0;
    logic [1:0] sb = 2'b00, aop = 2'b00;
    logic r2l_op = (k == K_STUR) || (k == K_CBZ) || (k == K_CBNZ);
    case (st)
      0: begin pcw = 1; mr = 1; irw = 1; sb = 2'b01; end
      1: begin sb = 2'b11; r2l = r2l_op; end
      2: begin sa = 1; sb = 2'b10; r2l = r2l_op; end
      3: begin iord = 1; mr = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin iord = 1; mw = 1; r2l = r2l_op; end
      6: begin sa = 1; aop = 2'b10; end
      7: rw = 1;
      8: begin sa = 1; aop = 2'b01; pcs = 1; r2l = r2l_op;
               pcw = (k == K_CBNZ) ? ~z : z; end
      9: ill = 1;
      default: ;
    endcase
    return {pcw, pcs, iord, mr, mw, irw, r2l, rw, m2r, sa, sb, aop, ill};
  endfunction

  // Runs one instruction cycle by cycle, starting in FETCH at the next
  // negedge. zmode: 0 random Zero, 1 force 0, 2 force 1. stop_at < 0 runs
  // the whole walk; otherwise the task returns after checking that index.
  task automatic run_instr(input logic [10:0] op, input int zmode,
                           input int stop_at);
    int k = op_kind(op);
    int n = walk_len(k);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) Op = op;
      Zero = (zmode == 0) ? 1'($urandom) : (zmode == 2);
      #1;
      check("state", 32'(state), 32'(walk_state(k, i)));
      check("ctrl", 32'(w_outs), 32'(exp_outs(walk_state(k, i), k, Zero)));
      if (i == stop_at) return;
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect and the held
  // reset across an edge, then releases just after a rising edge so the
  // following negedge still sees FETCH.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_ctrl"}, 32'(w_outs), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_held_state"}, 32'(state), 32'd0);
    check({tag, "_held_ctrl"}, 32'(w_outs), 32'd0);
    reset = 1'b0;
  endtask

  task automatic hold_illegal(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      Zero = 1'($urandom);
      #1;
      check("ill_state", 32'(state), 32'd9);
      check("ill_ctrl", 32'(w_outs), 32'(exp_outs(9, K_ILL, Zero)));
    end
  endtask

  initial begin
    logic [10:0] op;
    logic [10:0] rtypes [4] = '{11'b10001011000, 11'b11001011000,
                                11'b10001010000, 11'b10101010000};
    reset = 1'b1;
    Op    = '0;
    Zero  = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(w_outs), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_ctrl", 32'(w_outs), 32'd0);
    reset = 1'b0;

    // Directed cases
    run_instr(11'b11111000010, 0, -1);           // LDUR
    run_instr(11'b11111000000, 0, -1);           // STUR
    run_instr(11'b10001011000, 0, -1);           // ADD
    run_instr(11'b11001011000, 0, -1);           // SUB
    run_instr(11'b10110100101, 2, -1);           // CBZ taken
    run_instr(11'b10110100010, 1, -1);           // CBZ not taken
    run_instr(11'b11010011011, 0, -1);           // illegal
    hold_illegal(10);
    pulse_reset("ill_rst");
    run_instr(11'b11111000010, 0, 3);            // LDUR aborted in MEMREAD
    pulse_reset("abort_rst");
    run_instr(11'b10110101000, 1, -1);           // CBNZ / illegal by build
    if (op_kind(11'b10110101000) == K_ILL) begin
      hold_illegal(2);
      pulse_reset("cbnz_rst");
    end

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 8))
        0: op = 11'b11111000010;
        1: op = 11'b11111000000;
        2, 3: op = rtypes[$urandom_range(0, 3)];
        4, 5: op = {8'b10110100, 3'($urandom)};
        6: op = {8'b10110101, 3'($urandom)};
        default: op = 11'($urandom);
      endcase
      run_instr(op, 0, -1);
      if (op_kind(op) == K_ILL) begin
        hold_illegal(int'($urandom_range(1, 4)));
        pulse_reset("rnd_rst");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
